// File: rtl/lock_ctrl.sv
// lock_ctrl: confirm-driven lock sequencer (check, timed open, failure count, alarm lockout); optional set-password feature under LOCK_SETPW_EN
module lock_ctrl #(
    parameter int OPEN_CYC  = 16,
    parameter int ALARM_CYC = 64,
    parameter int MAX_FAIL  = 3,
    parameter int FAIL_W    = 3,
    parameter int TMR_W     = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              confirm,
    input  logic              close,
    input  logic              judge_ok,
    output logic              judge_en,
    output logic              unlock,
    output logic              alarm,
    output logic              busy,
    output logic              clear_entry,
    output logic [FAIL_W-1:0] fail_cnt
`ifdef LOCK_SETPW_EN
    ,
    input  logic              set_pw,
    output logic              pw_load
`endif
);
    typedef enum logic [1:0] {IDLE, CHECK, OPEN, ALARM} state_t;
    localparam logic [TMR_W-1:0]  OPEN_T  = TMR_W'(OPEN_CYC - 1);
    localparam logic [TMR_W-1:0]  ALARM_T = TMR_W'(ALARM_CYC - 1);
    localparam logic [FAIL_W:0]   MAX_F   = (FAIL_W+1)'(MAX_FAIL);
    state_t              state_q, state_d;
    logic [TMR_W-1:0]    timer_q, timer_d;
    logic [FAIL_W-1:0]   fail_q, fail_d;
    logic [FAIL_W:0]     fail_inc;
    logic                set_pw_hit;
    logic                judge_en_q, judge_en_d;
    logic                unlock_q, unlock_d;
    logic                alarm_q, alarm_d;
    logic                busy_q, busy_d;
    logic                clear_q, clear_d;
`ifdef LOCK_SETPW_EN
    logic                pw_load_q, pw_load_d;
    assign set_pw_hit = (state_q == OPEN) && set_pw && !close;
    assign pw_load    = pw_load_q;
`else
    assign set_pw_hit = 1'b0;
`endif
    assign fail_inc    = {1'b0, fail_q} + (FAIL_W+1)'(1);
    assign judge_en    = judge_en_q;
    assign unlock      = unlock_q;
    assign alarm       = alarm_q;
    assign busy        = busy_q;
    assign clear_entry = clear_q;
    assign fail_cnt    = fail_q;
    // state, counters and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            timer_q    <= '0;
            fail_q     <= '0;
            judge_en_q <= 1'b0;
            unlock_q   <= 1'b0;
            alarm_q    <= 1'b0;
            busy_q     <= 1'b0;
            clear_q    <= 1'b0;
`ifdef LOCK_SETPW_EN
            pw_load_q  <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            timer_q    <= timer_d;
            fail_q     <= fail_d;
            judge_en_q <= judge_en_d;
            unlock_q   <= unlock_d;
            alarm_q    <= alarm_d;
            busy_q     <= busy_d;
            clear_q    <= clear_d;
`ifdef LOCK_SETPW_EN
            pw_load_q  <= pw_load_d;
`endif
        end
    end
    // next state; judge_ok is only looked at in CHECK so an undefined value elsewhere is harmless
    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        fail_d  = fail_q;
        case (state_q)
            IDLE: if (confirm) state_d = CHECK;
            CHECK: begin
                if (judge_ok) begin
                    state_d = OPEN;
                    fail_d  = '0;
                    timer_d = OPEN_T;
                end else if (fail_inc >= MAX_F) begin
                    state_d = ALARM;
                    fail_d  = FAIL_W'(MAX_FAIL);
                    timer_d = ALARM_T;
                end else begin
                    state_d = IDLE;
                    fail_d  = fail_inc[FAIL_W-1:0];
                end
            end
            OPEN: begin
                if (close || set_pw_hit || timer_q == '0) begin
                    state_d = IDLE;
                    timer_d = '0;
                end else timer_d = timer_q - TMR_W'(1);
            end
            ALARM: begin
                if (timer_q == '0) begin
                    state_d = IDLE;
                    fail_d  = '0;
                end else timer_d = timer_q - TMR_W'(1);
            end
            default: state_d = IDLE;
        endcase
    end
    // outputs follow the state being entered; clear pulses after every check and on a password load
    always_comb begin
        judge_en_d = state_d == CHECK;
        unlock_d   = state_d == OPEN;
        alarm_d    = state_d == ALARM;
        busy_d     = state_d != IDLE;
        clear_d    = (state_q == CHECK) || set_pw_hit;
`ifdef LOCK_SETPW_EN
        pw_load_d  = set_pw_hit;
`endif
    end
endmodule
